mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the fetch stage (port 0) and the load/store stage (port 1) of the CPU.
- Arbitrates round-robin and sequences the fixed-latency memory access.
- Drives the select of the external 2:1 32-bit address/write-data selectors and returns read data with a one-cycle ack per port.

Parameters:
- MEM_LAT, 2: memory read/write latency in cycles, from first mem_en cycle to mem_rdata valid; legal range 1..15.
- CNT_W, 4: width of the internal latency counter; must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0  input  1  fetch request; held high until ack0.
- we0  input  1  fetch write enable; normally 0, honoured if 1.
- req1  input  1  data request; held high until ack1.
- we1  input  1  data write enable (1 = store, 0 = load).
- mem_rdata  input  32  memory read data; valid in the final BUSY cycle.
- mem_en  output  1  memory enable.
- mem_we  output  1  memory write enable.
- sel_sig  output  1  select for the external address/wdata selectors; 0 = port 0, 1 = port 1.
- rdata  output  32  registered read data; valid while ack0 or ack1 is high.
- ack0  output  1  one-cycle completion pulse for port 0.
- ack1  output  1  one-cycle completion pulse for port 1.
- busy  output  1  high in BUSY and RESP.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, cnt=0, grant=0, last_grant=0.
  - rdata=0; mem_en, mem_we, ack0, ack1 and busy all 0; sel_sig=0.
  - Reset mid-access abandons the access; no ack is issued afterwards.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Outputs idle; sel_sig holds grant.
  - Neither req high: stay in IDLE.
  - Only one req high: grant that port.
  - Both req high: grant the port != last_grant, so after reset port 1 wins the first tie.
  - On grant: register grant and the granted port's we into we_r; last_grant <= granted port; cnt <= 0; go to BUSY.
- BUSY:
  - mem_en=1, mem_we=we_r, sel_sig=grant, busy=1.
  - cnt increments each cycle.
  - When cnt==MEM_LAT-1: capture mem_rdata into rdata (stores also capture, value don't-care); go to RESP.
  - BUSY lasts exactly MEM_LAT cycles.
- RESP:
  - ack[grant]=1 for exactly one cycle; mem_en=0; busy=1; rdata stable.
  - Always return to IDLE next cycle.
- Latency: req sampled high in IDLE at cycle 0 → mem_en cycles 1..MEM_LAT → ack at cycle MEM_LAT+1. Minimum period between back-to-back grants is MEM_LAT+2 cycles.
- Requester rules:
  - req must stay high, with we/address/wdata stable, from request until its ack cycle.
  - req still high in the cycle after ack is a new request.
  - A req dropped before grant is simply not served. A req dropped during BUSY does not abort the access; the ack is still issued.
- Request changes during BUSY/RESP are ignored, including a new req on the other port; they are evaluated only in IDLE.
- Never ack0 and ack1 together. Never mem_en outside BUSY.
- rdata holds its value between accesses.
- sel_sig is driven from the registered grant only, so it is glitch-free during BUSY.
- MEM_LAT=1: BUSY is one cycle; capture happens in that cycle.

Test Plan:
- Reset/idle: assert rst mid-sim with req0=1 → within the same cycle all outputs are 0 and the state is IDLE; after release with no req, mem_en stays 0 for 10 cycles.
- Single fetch read, MEM_LAT=2: req0=1 at cycle 0; memory returns 0x2402000A in cycle 2 → mem_en=1 in cycles 1-2, sel_sig=0, ack0=1 in cycle 3, rdata=0x2402000A; ack1 stays 0.
- Simultaneous requests after reset: req0=req1=1, we1=1 → port 1 granted first (sel_sig=1, mem_we=1, ack1 at cycle 3); port 0 granted next (IDLE at 4, BUSY 5-6, ack0 at cycle 7).
- Fairness: hold req0 and req1 high continuously for 8 accesses → grants alternate 1,0,1,0,...; no port is served twice in a row.
- Mid-access reset: rst pulsed during the 2nd BUSY cycle of a port-1 load → no ack1 ever appears; the next req0 is served normally with ack at cycle 3 relative to its request.
- MEM_LAT=1 build: req1=1 load → mem_en in cycle 1 only, ack1 in cycle 2, rdata equals the mem_rdata sampled in cycle 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one fixed-latency single-port memory between
// the fetch port (0) and the load/store port (1), returning read data with a one-cycle ack.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic        sel_sig,
    output logic [31:0] rdata,
    output logic        ack0,
    output logic        ack1,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              pick_s;

    // Round-robin choice: on a tie the port that did not win last time goes first.
    always_comb begin
        if (req0 && req1) begin
            pick_s = ~last_grant_q;
        end else if (req1) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b0;
            we_q         <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d      = S_BUSY;
                    grant_d      = pick_s;
                    last_grant_d = pick_s;
                    we_d         = pick_s ? we1 : we0;
                    cnt_d        = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    rdata_d = mem_rdata;
                    state_d = S_RESP;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only.
    always_comb begin
        mem_en = 1'b0;
        mem_we = 1'b0;
        ack0   = 1'b0;
        ack1   = 1'b0;
        busy   = 1'b0;
        case (state_q)
            S_BUSY: begin
                mem_en = 1'b1;
                mem_we = we_q;
                busy   = 1'b1;
            end
            S_RESP: begin
                ack0 = ~grant_q;
                ack1 = grant_q;
                busy = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign sel_sig = grant_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-schedule model checked every cycle,
// plus directed scenarios with hand-computed expectations (MEM_LAT=2 and MEM_LAT=1 builds).
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [31:0] mem_rdata;
    logic        mem_en, mem_we, sel_sig, ack0, ack1, busy;
    logic [31:0] rdata;

    logic        b_req1;
    logic        b_mem_en, b_mem_we, b_sel, b_ack0, b_ack1, b_busy;
    logic [31:0] b_rdata;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(L), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst), .req0(req0), .we0(we0), .req1(req1), .we1(we1),
        .mem_rdata(mem_rdata), .mem_en(mem_en), .mem_we(mem_we), .sel_sig(sel_sig),
        .rdata(rdata), .ack0(ack0), .ack1(ack1), .busy(busy)
    );

    mem_port_arbiter #(.MEM_LAT(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .rst(rst), .req0(1'b0), .we0(1'b0), .req1(b_req1), .we1(1'b0),
        .mem_rdata(mem_rdata), .mem_en(b_mem_en), .mem_we(b_mem_we), .sel_sig(b_sel),
        .rdata(b_rdata), .ack0(b_ack0), .ack1(b_ack1), .busy(b_busy)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Schedule model: an access granted at cycle s occupies the memory in
    // cycles s+1..s+L, is acked in s+L+1, and the next grant is possible at s+L+2.
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_start = 0;
    bit          m_port = 1'b0;
    bit          m_last = 1'b0;
    bit          m_we = 1'b0;
    logic [31:0] m_rdata = 32'd0;

    function automatic bit pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) return !last;
        return r1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_port   <= 1'b0;
            m_last   <= 1'b0;
            m_we     <= 1'b0;
            m_rdata  <= 32'd0;
        end else begin
            if (!m_active && (req0 || req1)) begin
                m_active <= 1'b1;
                m_start  <= cyc;
                m_port   <= pick(req0, req1, m_last);
                m_last   <= pick(req0, req1, m_last);
                m_we     <= pick(req0, req1, m_last) ? we1 : we0;
            end else if (m_active && cyc == m_start + L + 1) begin
                m_active <= 1'b0;
            end
            if (m_active && cyc == m_start + L) m_rdata <= mem_rdata;
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk1("mdl_mem_en", mem_en, m_active && cyc <= m_start + L);
            chk1("mdl_mem_we", mem_we, m_active && cyc <= m_start + L && m_we);
            chk1("mdl_busy", busy, m_active);
            chk1("mdl_sel", sel_sig, m_port);
            chk1("mdl_ack0", ack0, m_active && cyc == m_start + L + 1 && !m_port);
            chk1("mdl_ack1", ack1, m_active && cyc == m_start + L + 1 && m_port);
            chk1("mdl_both_ack", ack0 && ack1, 1'b0);
            chk32("mdl_rdata", rdata, m_rdata);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    bit seq[$];

    initial begin
        rst = 1'b0; req0 = 1'b0; we0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        mem_rdata = 32'd0; b_req1 = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1'b1;
        repeat (2) tick;

        // Reset while an access is in flight, then quiet idle.
        req0 = 1'b1;
        tick;
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_mem_en", mem_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_ack0", ack0, 1'b0);
        chk1("rst_sel", sel_sig, 1'b0);
        chk32("rst_rdata", rdata, 32'd0);
        req0 = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            @(negedge clk);
            chk1("idle_mem_en", mem_en, 1'b0);
        end

        // Single fetch read.
        tick; req0 = 1'b1;
        tick; @(negedge clk);
        chk1("rd_en_c1", mem_en, 1'b1);
        chk1("rd_sel_c1", sel_sig, 1'b0);
        tick; mem_rdata = 32'h2402000A; @(negedge clk);
        chk1("rd_en_c2", mem_en, 1'b1);
        tick; @(negedge clk);
        chk1("rd_ack0_c3", ack0, 1'b1);
        chk1("rd_ack1_c3", ack1, 1'b0);
        chk32("rd_rdata_c3", rdata, 32'h2402000A);
        req0 = 1'b0;
        tick;

        // Simultaneous requests after reset: port 1 first.
        rst = 1'b1; tick; rst = 1'b0; tick;
        req0 = 1'b1; req1 = 1'b1; we1 = 1'b1;
        tick; @(negedge clk);
        chk1("tie_sel_c1", sel_sig, 1'b1);
        chk1("tie_we_c1", mem_we, 1'b1);
        tick;
        tick; @(negedge clk);
        chk1("tie_ack1_c3", ack1, 1'b1);
        req1 = 1'b0; we1 = 1'b0;
        tick; @(negedge clk);
        chk1("tie_idle_c4", busy, 1'b0);
        tick; @(negedge clk);
        chk1("tie_sel_c5", sel_sig, 1'b0);
        chk1("tie_en_c5", mem_en, 1'b1);
        tick;
        tick; @(negedge clk);
        chk1("tie_ack0_c7", ack0, 1'b1);
        req0 = 1'b0;
        tick;

        // Fairness with both requests held continuously.
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            tick;
            mem_rdata = 32'h1000_0000 + 32'(i);
            @(negedge clk);
            if (ack0) seq.push_back(1'b0);
            if (ack1) seq.push_back(1'b1);
        end
        tick; req0 = 1'b0; req1 = 1'b0;
        chk32("fair_count", 32'(seq.size()), 32'd8);
        for (int k = 0; k < 8 && k < seq.size(); k++) begin
            chk1("fair_order", seq[k], (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        repeat (6) tick;

        // Reset in the second BUSY cycle of a port-1 load.
        req1 = 1'b1;
        tick;
        tick; rst = 1'b1; req1 = 1'b0; @(negedge clk);
        chk1("mid_rst_ack1", ack1, 1'b0);
        chk1("mid_rst_en", mem_en, 1'b0);
        chk1("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick; @(negedge clk);
            chk1("mid_rst_no_ack1", ack1, 1'b0);
        end
        tick; req0 = 1'b1;
        tick; tick;
        tick; @(negedge clk);
        chk1("post_rst_ack0_c3", ack0, 1'b1);
        req0 = 1'b0;
        repeat (3) tick;

        // MEM_LAT=1 build: one BUSY cycle, capture in that cycle.
        b_req1 = 1'b1;
        tick; mem_rdata = 32'hDEADBEEF; @(negedge clk);
        chk1("lat1_en_c1", b_mem_en, 1'b1);
        chk1("lat1_sel_c1", b_sel, 1'b1);
        tick; mem_rdata = 32'd0; @(negedge clk);
        chk1("lat1_en_c2", b_mem_en, 1'b0);
        chk1("lat1_ack1_c2", b_ack1, 1'b1);
        chk1("lat1_ack0_c2", b_ack0, 1'b0);
        chk32("lat1_rdata_c2", b_rdata, 32'hDEADBEEF);
        b_req1 = 1'b0;
        tick; @(negedge clk);
        chk1("lat1_ack1_c3", b_ack1, 1'b0);
        chk1("lat1_busy_c3", b_busy, 1'b0);
        chk1("lat1_we", b_mem_we, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
